// File: rtl/serial_slave_port_pkg.sv
// Shared encodings for the serial slave port: FSM states, response codes and master IDs.
package serial_slave_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_MEM,
    ST_RESP,
    ST_RDATA,
    ST_SPLIT_WAIT,
    ST_REGRANT
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b01;
  localparam logic [1:0] RESP_SPLIT = 2'b10;
  localparam logic [1:0] RESP_ERROR = 2'b11;

  localparam logic [1:0] MASTER_NONE = 2'b00;
  localparam logic [1:0] MASTER_1    = 2'b10;
  localparam logic [1:0] MASTER_2    = 2'b01;

endpackage

// File: rtl/serial_slave_port_shift_reg.sv
// Generic MSB-first shift register with parallel load; load wins over shift.
// One cycle from shift_in/load_dat to q; no flow control, the caller sequences it.
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q,
  output logic         ser_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift_en) begin
      q <= {q[W-2:0], shift_in};
    end
  end

  assign ser_out = q[W-1];

endmodule

// File: rtl/serial_slave_port.sv
// Serial bus slave: decodes a request frame, does one local memory access, answers OKAY or SPLIT.
// OKAY one cycle after the access; a busy memory SPLITs the bus and re-requests the master later.
module serial_slave_port
  import serial_slave_port_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        slave_address,
  input  logic              address_bus,
  input  logic              w_data_bus,
  output wire               r_data_bus,
  output wire  [1:0]        response_bus,
  input  logic [1:0]        granted_master,
  output logic [1:0]        split_request,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_MAX = (ADDR_W + 2 > DATA_W) ? ADDR_W + 2 : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W + 2);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [1:0]       split_id_q, split_id_d;
  logic             rd_cap_q;

  logic             addr_shift, wd_shift, rd_en, access, resp_en;
  logic [1:0]       resp_code;

  logic [ADDR_W:0]   addr_sr_q;
  logic [ADDR_W+1:0] frame_peek;
  logic [1:0]        id_peek;
  logic              rd_ser;
  logic              addr_ser_unused, wd_ser_unused;
  logic [DATA_W-1:0] rd_sr_unused;

  // The ID decision is taken on the last address bit, so look at the bit still on the wire.
  assign frame_peek = {addr_sr_q, address_bus};
  assign id_peek    = frame_peek[ADDR_W+1:ADDR_W];
  assign mem_addr   = addr_sr_q[ADDR_W-1:0];

  serial_shift_reg #(.W(ADDR_W + 1)) u_addr_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_dat ('0),
    .shift_en (addr_shift),
    .shift_in (address_bus),
    .q        (addr_sr_q),
    .ser_out  (addr_ser_unused)
  );

  serial_shift_reg #(.W(DATA_W)) u_wdata_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_dat ('0),
    .shift_en (wd_shift),
    .shift_in (w_data_bus),
    .q        (mem_wdata),
    .ser_out  (wd_ser_unused)
  );

  serial_shift_reg #(.W(DATA_W)) u_rdata_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_cap_q),
    .load_dat (mem_rdata),
    .shift_en (rd_en),
    .shift_in (1'b0),
    .q        (rd_sr_unused),
    .ser_out  (rd_ser)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      split_id_q <= MASTER_NONE;
      rd_cap_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      split_id_q <= split_id_d;
      rd_cap_q   <= mem_re;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    split_id_d    = split_id_q;
    addr_shift    = 1'b0;
    wd_shift      = 1'b0;
    rd_en         = 1'b0;
    access        = 1'b0;
    resp_en       = 1'b0;
    resp_code     = RESP_OKAY;
    split_request = MASTER_NONE;
    case (state_q)
      ST_IDLE: begin
        if (address_bus) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
        end
      end
      ST_ADDR: begin
        // Count 0 is the mode bit; counts 1..ADDR_W+2 carry ID then address.
        if (cnt_q == '0) begin
          write_d = address_bus;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          addr_shift = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (id_peek != slave_address) state_d = ST_IDLE;
            else if (write_q)             state_d = ST_WDATA;
            else                          state_d = ST_MEM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WDATA: begin
        wd_shift = 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = ST_MEM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          resp_en    = 1'b1;
          resp_code  = RESP_SPLIT;
          split_id_d = granted_master;
          state_d    = ST_SPLIT_WAIT;
        end
      end
      ST_SPLIT_WAIT: begin
        if (mem_ready) begin
          access  = 1'b1;
          state_d = ST_REGRANT;
        end
      end
      ST_REGRANT: begin
        if (granted_master == split_id_q) state_d = ST_RESP;
        else                              split_request = split_id_q;
      end
      ST_RESP: begin
        resp_en = 1'b1;
        cnt_d   = '0;
        state_d = write_q ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: begin
        rd_en = 1'b1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we       = access & write_q;
  assign mem_re       = access & ~write_q;
  assign response_bus = resp_en ? resp_code : 2'bzz;
  assign r_data_bus   = rd_en ? rd_ser : 1'bz;

endmodule

// File: tb/tb_serial_slave_port.sv
// Bench for serial_slave_port: table of request frames plus reset-abort sequence, memory scoreboard.
module tb_serial_slave_port;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam logic [1:0] MY_ID = 2'b01;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              address_bus = 1'b0;
  logic              w_data_bus = 1'b0;
  logic [1:0]        granted_master = 2'b00;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b1;
  logic [1:0]        split_request;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_re;
  wire               r_data_bus_w;
  wire  [1:0]        response_bus_w;

  // Released buses read back as all ones.
  pullup pu_rd  (r_data_bus_w);
  pullup pu_rs0 (response_bus_w[0]);
  pullup pu_rs1 (response_bus_w[1]);

  serial_slave_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .slave_address  (MY_ID),
    .address_bus    (address_bus),
    .w_data_bus     (w_data_bus),
    .r_data_bus     (r_data_bus_w),
    .response_bus   (response_bus_w),
    .granted_master (granted_master),
    .split_request  (split_request),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        id;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                delay;
    logic [1:0]        master;
  } vec_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  vec_t vecs[8];

  int n_vec = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  logic [1:0]        s_resp;
  logic              s_rd;
  logic [1:0]        s_sreq;
  logic              re_prev = 1'b0;
  logic [DATA_W-1:0] cur_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle: sample mid-cycle, score memory accesses, then model memory read latency.
  task automatic tick();
    acc_t e;
    @(negedge clk);
    s_resp = response_bus_w;
    s_rd   = r_data_bus_w;
    s_sreq = split_request;
    if (mem_we || mem_re) begin
      acc_cnt++;
      check("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_access", {30'd0, mem_we, mem_re}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("access_kind", {31'd0, mem_we}, {31'd0, e.we});
        check("mem_addr", {20'd0, mem_addr}, {20'd0, e.addr});
        if (e.we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
      end
    end
    re_prev = mem_re;
    @(posedge clk);
    #1;
    mem_rdata = re_prev ? cur_rdata : ~cur_rdata;
  endtask

  task automatic send_frame(input vec_t v);
    logic [ADDR_W+2:0] bits;
    bits = {v.wr, v.id, v.addr};
    address_bus = 1'b1;
    tick();
    for (int i = ADDR_W + 2; i >= 0; i--) begin
      address_bus = bits[i];
      tick();
    end
    address_bus = 1'b0;
  endtask

  task automatic send_wdata(input logic [DATA_W-1:0] d, input int nbits);
    for (int i = DATA_W - 1; i >= DATA_W - nbits; i--) begin
      w_data_bus = d[i];
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int acc0, k, split_cnt, sr_cycles, exp_lat;
    logic got_ok, bad_sr, early_sr, granted_back;
    logic [1:0]        first_rd_resp;
    logic [DATA_W-1:0] got;
    acc0 = acc_cnt;
    cur_rdata = v.rdata;
    granted_master = v.master;
    mem_ready = 1'b1;
    if (v.id == MY_ID) exp_q.push_back('{v.wr, v.addr, v.wdata});
    send_frame(v);
    if (v.wr) send_wdata(v.wdata, DATA_W);
    w_data_bus = 1'b0;
    if (v.id != MY_ID) begin
      for (int i = 0; i < 6; i++) begin
        tick();
        check("miss_resp_released", {30'd0, s_resp}, 32'd3);
        check("miss_rdata_released", {31'd0, s_rd}, 32'd1);
      end
      check("miss_no_access", acc_cnt - acc0, 0);
      return;
    end
    k = 0; split_cnt = 0; sr_cycles = 0;
    got_ok = 1'b0; bad_sr = 1'b0; early_sr = 1'b0; granted_back = 1'b0;
    while (k < 60 && !got_ok) begin
      mem_ready = (k >= v.delay);
      if (v.delay == 0 || split_cnt == 0) begin
        granted_master = v.master;
      end else if (sr_cycles >= 3) begin
        granted_master = v.master;
        granted_back = 1'b1;
      end else begin
        granted_master = 2'b00;
      end
      address_bus = 1'($urandom_range(0, 1));
      tick();
      if (s_resp == 2'b10) split_cnt++;
      if (s_sreq != 2'b00) begin
        sr_cycles++;
        if (s_sreq != v.master || granted_back) bad_sr = 1'b1;
        if (acc_cnt == acc0) early_sr = 1'b1;
      end
      if (s_resp == 2'b01) got_ok = 1'b1;
      k++;
    end
    address_bus = 1'b0;
    mem_ready = 1'b1;
    exp_lat = (v.delay == 0) ? 2 : v.delay + 6;
    check("okay_seen", {31'd0, got_ok}, 32'd1);
    check("okay_latency", k, exp_lat);
    check("split_resp_cycles", split_cnt, (v.delay > 0) ? 1 : 0);
    check("split_req_cycles", sr_cycles, (v.delay > 0) ? 3 : 0);
    check("split_req_value", {31'd0, bad_sr}, 32'd0);
    check("split_req_before_access", {31'd0, early_sr}, 32'd0);
    check("access_count", acc_cnt - acc0, 1);
    if (!v.wr) begin
      got = '0;
      first_rd_resp = 2'b00;
      for (int i = DATA_W - 1; i >= 0; i--) begin
        address_bus = (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        got[i] = s_rd;
        if (i == DATA_W - 1) first_rd_resp = s_resp;
      end
      address_bus = 1'b0;
      check("okay_one_cycle_rd", {30'd0, first_rd_resp}, 32'd3);
      check("r_data_bus", {24'd0, got}, {24'd0, v.rdata});
    end
    tick();
    check("resp_released_after", {30'd0, s_resp}, 32'd3);
    check("rdata_released_after", {31'd0, s_rd}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    vec_t v;
    int acc0;
    vecs[0] = '{2'b01, 1'b1, 12'h0A5, 8'h3C, 8'h00, 0, 2'b10};
    vecs[1] = '{2'b01, 1'b0, 12'h123, 8'h00, 8'hA7, 0, 2'b10};
    vecs[2] = '{2'b10, 1'b1, 12'h0FF, 8'h55, 8'h00, 0, 2'b10};
    vecs[3] = '{2'b01, 1'b0, 12'h456, 8'h00, 8'h5A, 5, 2'b10};
    vecs[4] = '{2'b01, 1'b1, 12'hFFF, 8'hFF, 8'h00, 2, 2'b01};
    vecs[5] = '{2'b11, 1'b0, 12'h321, 8'h00, 8'h99, 0, 2'b01};
    vecs[6] = '{2'b01, 1'b0, 12'h000, 8'h00, 8'h01, 0, 2'b01};
    vecs[7] = '{2'b01, 1'b1, 12'h800, 8'h80, 8'h00, 0, 2'b10};

    #2 reset = 1'b0;
    #1;
    check("rst_resp_released", {30'd0, response_bus_w}, 32'd3);
    check("rst_rdata_released", {31'd0, r_data_bus_w}, 32'd1);
    check("rst_split_request", {30'd0, split_request}, 32'd0);
    check("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abort a write while its fifth data bit is on the wire.
    v = '{2'b01, 1'b1, 12'h321, 8'hC9, 8'h00, 0, 2'b10};
    acc0 = acc_cnt;
    send_frame(v);
    send_wdata(v.wdata, 4);
    w_data_bus = v.wdata[3];
    reset = 1'b0;
    #1;
    check("abort_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    check("abort_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("abort_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("abort_split_request", {30'd0, split_request}, 32'd0);
    check("abort_resp_released", {30'd0, response_bus_w}, 32'd3);
    check("abort_rdata_released", {31'd0, r_data_bus_w}, 32'd1);
    repeat (3) tick();
    reset = 1'b1;
    w_data_bus = 1'b0;
    repeat (12) tick();
    check("abort_no_access", acc_cnt - acc0, 0);
    run_vec(vecs[1]);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_slave_port.md
SERIAL_SLAVE_PORT -- requirements
Module: serial_slave_port

Interface
REQ-001 Parameter ADDR_W, default 12, memory word address width.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 slave_address  input  2  this port's bus ID (01/10/11), static after reset.
REQ-006 address_bus  input  1  serial request frame from granted master.
REQ-007 w_data_bus  input  1  serial write data from granted master.
REQ-008 r_data_bus  output  1  serial read data, tri-stated when not driving.
REQ-009 response_bus  output  2  response code, tri-stated when not driving.
REQ-010 granted_master  input  2  one-hot current bus owner from arbiter (10=master1, 01=master2, 00=none).
REQ-011 split_request  output  2  one-hot master to re-grant after split, 00 = none.
REQ-012 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_we  output  1, mem_re  output  1: local memory request.
REQ-013 mem_rdata  input  DATA_W  valid the cycle after a mem_re cycle; mem_ready  input  1  memory can accept a request this cycle.

Function
REQ-014 Frame on address_bus: start bit 1, mode bit (1=write, 0=read), 2-bit slave ID MSB first, ADDR_W address bits MSB first; address_bus is 0 between frames.
REQ-015 States: IDLE, ADDR, WDATA, MEM, RESP, RDATA, SPLIT_WAIT, REGRANT.
REQ-016 IDLE: address_bus=1 sampled -> ADDR; shift counter cleared.
REQ-017 ADDR: shift 2+ADDR_W bits; after last bit, ID != slave_address -> IDLE with no bus drive; match+write -> WDATA; match+read -> MEM.
REQ-018 WDATA: shift DATA_W bits from w_data_bus MSB first, first bit sampled the cycle after the last address bit; then -> MEM.
REQ-019 MEM with mem_ready=1: one-cycle mem_we (write) or mem_re (read) pulse with mem_addr/mem_wdata valid; read captures mem_rdata next cycle; -> RESP.
REQ-020 MEM with mem_ready=0: drive response_bus=10 (SPLIT) one cycle, latch granted_master into split_id, -> SPLIT_WAIT.
REQ-021 SPLIT_WAIT: when mem_ready=1 perform REQ-019 access, then assert split_request=split_id, -> REGRANT.
REQ-022 REGRANT: hold split_request until granted_master==split_id, then clear to 00 same cycle and -> RESP.
REQ-023 RESP: drive response_bus=01 (OKAY) exactly one cycle; write -> IDLE; read -> RDATA.
REQ-024 RDATA: drive r_data_bus DATA_W cycles MSB first, then -> IDLE.
REQ-025 response_bus=00 never driven by this port; both bus outputs high-impedance outside RESP, SPLIT cycle and RDATA.
REQ-026 Start bits on address_bus outside IDLE are ignored; mem_we and mem_re never high together.
REQ-027 One outstanding split only; new frames are not decoded in SPLIT_WAIT/REGRANT.

Reset
REQ-028 reset low: state IDLE, counters 0, split_request=00, mem_we=mem_re=0, mem_addr/mem_wdata=0, bus outputs high-impedance, immediately and asynchronously.
REQ-029 reset asserted mid-transaction aborts it with no memory access issued afterwards.

Structure
REQ-030 Shared package holds state encoding, response codes (OKAY=01, SPLIT=10, ERROR=11) and master one-hot IDs.
REQ-031 One sub-module serial_shift_reg (parameterised width, shift-in/shift-out, load) reused for address, write data and read data.

Verification
REQ-032 ID 01, write addr 0x0A5 data 0x3C, mem_ready=1 -> one mem_we pulse addr 0x0A5 wdata 0x3C, then response 01 one cycle.
REQ-033 ID 01, read addr 0x123, mem_rdata=0xA7 -> mem_re pulse, response 01, r_data_bus 1,0,1,0,0,1,1,1.
REQ-034 Frame to ID 10 while port is ID 01 -> no mem access, outputs stay high-impedance, IDLE after frame.
REQ-035 Read by master1 with mem_ready=0 for 5 cycles -> response 10, split_request=10 after access, cleared when granted_master=10, then OKAY and data.
REQ-036 reset low during WDATA bit 4 -> outputs reset values at once; next valid frame completes normally.
